// File: rtl/neo_status_pkg.sv
// Shared constants, snapshot payload and ASCII helpers for the status
// transmitter.
//   FRAME_LEN    bytes per status frame
//   snap_t       status captured when a frame is accepted
//   nib2ascii    BCD nibble -> ASCII digit, '?' for non-decimal nibbles
//   bin5_to_bcd  0..31 -> {tens, ones}
//   frame_byte   byte i of the frame built from a snapshot
package neo_status_pkg;

  localparam int unsigned FRAME_LEN = 14;
  localparam int unsigned IDX_W     = 4;

  localparam logic [7:0] HASH  = 8'h23;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] QMARK = 8'h3F;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } tx_state_e;

  typedef struct packed {
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        activada;
    logic        sonando;
    logic        ubicacion;
    logic [23:0] hora;
  } snap_t;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (ZERO + 8'(n)) : QMARK;
  endfunction

  function automatic logic [7:0] bin5_to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [4:0] rem;
    if (v >= 5'd30) begin
      tens = 4'd3;
      rem  = v - 5'd30;
    end else if (v >= 5'd20) begin
      tens = 4'd2;
      rem  = v - 5'd20;
    end else if (v >= 5'd10) begin
      tens = 4'd1;
      rem  = v - 5'd10;
    end else begin
      tens = 4'd0;
      rem  = v;
    end
    return {tens, 4'(rem)};
  endfunction

  function automatic logic [7:0] frame_byte(input snap_t s, input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = HASH;
      4'd1:    b = ZERO + 8'(s.tens);
      4'd2:    b = ZERO + 8'(s.ones);
      4'd3:    b = ZERO + 8'(s.activada);
      4'd4:    b = ZERO + 8'(s.sonando);
      4'd5:    b = ZERO + 8'(s.ubicacion);
      4'd6:    b = nib2ascii(s.hora[23:20]);
      4'd7:    b = nib2ascii(s.hora[19:16]);
      4'd8:    b = nib2ascii(s.hora[15:12]);
      4'd9:    b = nib2ascii(s.hora[11:8]);
      4'd10:   b = nib2ascii(s.hora[7:4]);
      4'd11:   b = nib2ascii(s.hora[3:0]);
      4'd12:   b = CR;
      4'd13:   b = LF;
      default: b = HASH;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/neo_status_tx_uart.sv
// 8N1 byte serializer with back-to-back reload.
//   clk, rst     clock, synchronous active-high reset
//   start, data  byte request; taken when idle or in the last stop-bit cycle
//   tx           serial line, idles high
//   busy         a byte is on the line
//   done         one-cycle pulse after the edge that ends a stop bit
//   stop_end_c   last cycle of the stop bit (reload point)
module uart_tx_byte #(
  parameter int unsigned BIT_CYCLES = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       stop_end_c
);

  localparam int unsigned CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [3:0]  STOP_BIT = 4'd9;
  localparam logic [3:0]  LAST_D   = 4'd8;

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [7:0]       sh_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end_c;
  logic             load_c;

  assign bit_end_c  = busy_q && (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign stop_end_c = bit_end_c && (bit_q == STOP_BIT);
  // Reloading in the last stop-bit cycle keeps consecutive bytes gapless.
  assign load_c     = start && (!busy_q || stop_end_c);

  // Bit timing and shifter; bit_q 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= stop_end_c;
      if (load_c) begin
        tx_q   <= 1'b0;
        busy_q <= 1'b1;
        cnt_q  <= '0;
        bit_q  <= '0;
        sh_q   <= data;
      end else if (bit_end_c) begin
        cnt_q <= '0;
        if (bit_q == STOP_BIT) begin
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == LAST_D) begin
            tx_q <= 1'b1;
          end else begin
            tx_q <= sh_q[0];
            sh_q <= {1'b0, sh_q[7:1]};
          end
        end
      end else if (busy_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/neo_status_tx.sv
// Status frame transmitter: snapshots occupancy, alarm, blind and time
// status and sends a 14-byte ASCII frame over 8N1.
//   clk, rst    clock, synchronous active-high reset
//   send        frame request (level or pulse), taken only when idle
//   numero_p    occupancy count; a change can also request a frame
//   activada, sonando, ubicacion   status flags
//   hora        packed BCD hh:mm:ss
//   tx          serial line
//   busy        frame in progress
//   frame_done  one-cycle pulse at frame end
module neo_status_tx
  import neo_status_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BAUD           = 9600,
  parameter bit          AUTO_ON_CHANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [4:0]  numero_p,
  input  logic        activada,
  input  logic        sonando,
  input  logic        ubicacion,
  input  logic [23:0] hora,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned      BIT_CYCLES = CLK_HZ / BAUD;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);

  tx_state_e        state_q;
  logic [IDX_W-1:0] idx_q;
  snap_t            snap_q;
  logic             pending_q;
  logic             frame_done_q;
  logic [4:0]       shadow_q;

  snap_t            snap_c;
  logic [7:0]       bcd_c;
  logic             change_c;
  logic             req_c;
  logic             accept_c;
  logic             u_start_c;
  logic [7:0]       u_data_c;
  logic             u_stop_end_c;
  logic             u_done;

  // Request qualification and snapshot source.
  always_comb begin
    bcd_c            = bin5_to_bcd(numero_p);
    snap_c           = '0;
    snap_c.tens      = bcd_c[7:4];
    snap_c.ones      = bcd_c[3:0];
    snap_c.activada  = activada;
    snap_c.sonando   = sonando;
    snap_c.ubicacion = ubicacion;
    snap_c.hora      = hora;
    change_c         = (numero_p != shadow_q);
    req_c            = send || (AUTO_ON_CHANGE && change_c) || pending_q;
    accept_c         = (state_q == ST_IDLE) && req_c;
  end

  // Byte feed: '#' at accept, then the byte after the one on the line.
  always_comb begin
    u_data_c  = HASH;
    u_start_c = accept_c;
    if (state_q == ST_SHIFT) begin
      u_data_c  = frame_byte(snap_q, idx_q + IDX_W'(1));
      u_start_c = (idx_q != LAST_IDX);
    end
  end

  // Frame FSM; idx_q follows the byte currently on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      shadow_q     <= numero_p;
    end else begin
      shadow_q     <= numero_p;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q   <= ST_SHIFT;
            idx_q     <= '0;
            snap_q    <= snap_c;
            pending_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (AUTO_ON_CHANGE && change_c) pending_q <= 1'b1;
          if (u_stop_end_c && (idx_q == LAST_IDX)) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
          end else if (u_done) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_uart (
    .clk        (clk),
    .rst        (rst),
    .start      (u_start_c),
    .data       (u_data_c),
    .tx         (tx),
    .busy       (busy),
    .done       (u_done),
    .stop_end_c (u_stop_end_c)
  );

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_neo_status_tx.sv
// Directed bench for neo_status_tx at 16 clocks per bit.
module tb_neo_status_tx;

  localparam int unsigned BC        = 16;
  localparam int unsigned BYTE_CYC  = 10 * BC;
  localparam int unsigned FRAME_CYC = 14 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic        send0 = 1'b0;
  logic [4:0]  numero_p = 5'd0;
  logic        activada = 1'b0;
  logic        sonando = 1'b0;
  logic        ubicacion = 1'b0;
  logic [23:0] hora = 24'h0;
  logic        tx, busy, frame_done;
  logic        tx0, busy0, frame_done0;

  always #5 clk = ~clk;

  neo_status_tx #(.CLK_HZ(1600), .BAUD(100), .AUTO_ON_CHANGE(1'b1)) dut (
    .clk(clk), .rst(rst), .send(send), .numero_p(numero_p), .activada(activada),
    .sonando(sonando), .ubicacion(ubicacion), .hora(hora),
    .tx(tx), .busy(busy), .frame_done(frame_done));

  neo_status_tx #(.CLK_HZ(1600), .BAUD(100), .AUTO_ON_CHANGE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .send(send0), .numero_p(numero_p), .activada(activada),
    .sonando(sonando), .ubicacion(ubicacion), .hora(hora),
    .tx(tx0), .busy(busy0), .frame_done(frame_done0));

  typedef struct {
    logic [4:0]   num;
    logic         act;
    logic         son;
    logic         ubi;
    logic [23:0]  hora;
    logic [111:0] exp;
  } vec_t;

  vec_t         vecs [4];
  logic         samp [FRAME_CYC];
  logic [111:0] exp_frame;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Both instances quiet for the given number of cycles.
  task automatic expect_idle(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0 || tx !== 1'b1 ||
          busy0 !== 1'b0 || frame_done0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    check($sformatf("%s idle", tag), bad, 0);
  endtask

  // Called on the negedge right after the accept edge; decodes exp_frame.
  task automatic capture_frame(input string tag);
    int          busy_drops = 0;
    int          early_done = 0;
    int          unstable = 0;
    int          framing = 0;
    logic [23:0] h_save = 24'h0;
    logic        a_save = 1'b0;
    for (int n = 0; n < int'(FRAME_CYC); n++) begin
      if (n > 0) @(negedge clk);
      samp[n] = tx;
      if (busy !== 1'b1) busy_drops++;
      if (frame_done !== 1'b0) early_done++;
      if (n == 500) begin
        h_save = hora; a_save = activada;
        hora = ~hora; activada = ~activada;
      end
      if (n == 1500) begin
        hora = h_save; activada = a_save;
      end
    end
    @(negedge clk);
    check($sformatf("%s frame_done at 2240", tag), frame_done, 1);
    check($sformatf("%s busy low at end", tag), busy, 0);
    check($sformatf("%s tx high at end", tag), tx, 1);
    check($sformatf("%s busy held", tag), busy_drops, 0);
    check($sformatf("%s no early done", tag), early_done, 0);
    for (int b = 0; b < 14; b++) begin
      int         base;
      logic [7:0] byt;
      base = b * int'(BYTE_CYC);
      for (int j = 0; j < 10; j++)
        for (int k = 1; k < int'(BC); k++)
          if (samp[base + j*int'(BC) + k] !== samp[base + j*int'(BC)]) unstable++;
      if (samp[base + 8] !== 1'b0) framing++;
      if (samp[base + 9*int'(BC) + 8] !== 1'b1) framing++;
      for (int k = 0; k < 8; k++) byt[k] = samp[base + (k+1)*int'(BC) + 8];
      check($sformatf("%s byte%0d", tag, b), byt, exp_frame[111 - 8*b -: 8]);
    end
    check($sformatf("%s bit width 16", tag), unstable, 0);
    check($sformatf("%s start/stop", tag), framing, 0);
    @(negedge clk);
    check($sformatf("%s done one cycle", tag), frame_done, 0);
  endtask

  task automatic run_vec(input int i, input string tag);
    @(negedge clk);
    numero_p = vecs[i].num; activada = vecs[i].act; sonando = vecs[i].son;
    ubicacion = vecs[i].ubi; hora = vecs[i].hora; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check($sformatf("%s accept busy", tag), busy, 1);
    check($sformatf("%s accept start bit", tag), tx, 0);
    exp_frame = vecs[i].exp;
    capture_frame(tag);
    expect_idle(tag, 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bad;
    vecs[0] = '{5'd17, 1'b1, 1'b0, 1'b1, 24'h123456, 112'h23_31_37_31_30_31_31_32_33_34_35_36_0D_0A};
    vecs[1] = '{5'd31, 1'b0, 1'b1, 1'b0, 24'h1A5F09, 112'h23_33_31_30_31_30_31_3F_35_3F_30_39_0D_0A};
    vecs[2] = '{5'd0,  1'b1, 1'b1, 1'b1, 24'h235959, 112'h23_30_30_31_31_31_32_33_35_39_35_39_0D_0A};
    vecs[3] = '{5'd9,  1'b0, 1'b0, 1'b0, 24'hFFFFFF, 112'h23_30_39_30_30_30_3F_3F_3F_3F_3F_3F_0D_0A};

    // Reset with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset tx c%0d", i), tx, 1);
      check($sformatf("reset busy c%0d", i), busy, 0);
      check($sformatf("reset done c%0d", i), frame_done, 0);
      numero_p = 5'(i * 7 + 3); send = ~send; activada = ~activada; hora = ~hora;
    end
    numero_p = 5'd0; send = 1'b0; activada = 1'b0; hora = 24'h0;
    @(negedge clk);
    check("reset tx last", tx, 1);
    rst = 1'b0;
    expect_idle("post reset", 30);

    // Table of frames.
    for (int i = 0; i < 4; i++) run_vec(i, $sformatf("vec%0d", i));

    // Send held across a frame with count changes: one extra frame.
    @(negedge clk);
    numero_p = 5'd5; activada = 1'b0; sonando = 1'b0; ubicacion = 1'b1;
    hora = 24'h090000; send = 1'b1;
    @(negedge clk);
    check("t3 accept busy", busy, 1);
    check("t3 accept start", tx, 0);
    cnt = 0;
    while (frame_done !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 300) numero_p = 5'd6;
      if (cnt == 600) numero_p = 5'd7;
    end
    check("t3 frame length", cnt, FRAME_CYC);
    check("t3 done busy", busy, 0);
    check("t3 done tx", tx, 1);
    @(negedge clk);
    check("t3 restart busy", busy, 1);
    check("t3 restart start", tx, 0);
    send = 1'b0;
    exp_frame = 112'h23_30_37_30_30_31_30_39_30_30_30_30_0D_0A;
    capture_frame("t3 second");
    expect_idle("t3 no third", 100);

    // Reset in the middle of byte 5.
    @(negedge clk);
    numero_p = 5'd12; activada = 1'b1; sonando = 1'b1; ubicacion = 1'b0;
    hora = 24'h101010; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("t5 accept busy", busy, 1);
    repeat (5 * BYTE_CYC + 40) @(negedge clk);
    check("t5 mid byte busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 abort tx", tx, 1);
    check("t5 abort busy", busy, 0);
    check("t5 abort done", frame_done, 0);
    rst = 1'b0;
    expect_idle("t5 after abort", int'(FRAME_CYC) + 100);
    run_vec(0, "t5 resend");

    // Count change while idle: only the auto instance starts.
    @(negedge clk);
    numero_p = 5'd18;
    @(negedge clk);
    check("t6 auto busy", busy, 1);
    check("t6 auto start", tx, 0);
    check("t6 manual busy", busy0, 0);
    check("t6 manual tx", tx0, 1);
    cnt = 0;
    bad = 0;
    while (frame_done !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    check("t6 auto frame length", cnt, FRAME_CYC);
    check("t6 manual stays idle", bad, 0);
    expect_idle("t6 end", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
